// File: rtl/alu_seq_pkg.sv
// Shared definitions for the accumulator-ALU command sequencer.
// Holds the datapath widths, the command opcode encoding, the FSM state
// type and the ALU strobe bundle that the decoder hands to the top level.
package alu_seq_pkg;

   localparam int unsigned WORD_W = 8;   // datapath / sysbus width
   localparam int unsigned OP_W   = 3;   // command opcode width
   localparam int unsigned CNT_W  = 4;   // shift-count field width

   localparam logic [OP_W-1:0] OP_LOAD  = 3'd0;
   localparam logic [OP_W-1:0] OP_ADD   = 3'd1;
   localparam logic [OP_W-1:0] OP_DEC   = 3'd2;
   localparam logic [OP_W-1:0] OP_LSH   = 3'd3;
   localparam logic [OP_W-1:0] OP_RSH   = 3'd4;
   localparam logic [OP_W-1:0] OP_MOD2  = 3'd5;
   localparam logic [OP_W-1:0] OP_READ  = 3'd6;
   localparam logic [OP_W-1:0] OP_CNTDN = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   // ALU control strobes, one bit per ALU control input
   typedef struct packed {
      logic acc_bus;
      logic load_acc;
      logic alu_acc;
      logic alu_add;
      logic alu_sub;
      logic alu_lshift;
      logic alu_rshift;
      logic alu_mod2;
   } strobe_t;

endpackage

// File: rtl/alu_seq_decode.sv
// Strobe decoder for the ALU sequencer.
// Maps (state, registered opcode) to the ALU strobe bundle and the enable
// for the sequencer's own sysbus drive. Strobes are only ever non-zero in
// EXEC. CNTDN additionally looks at z_flag so the terminating cycle issues
// no decrement.
//   i_state     : current sequencer state
//   i_op        : registered command opcode
//   i_z_flag    : ALU accumulator-zero flag
//   o_strobe    : ALU strobe bundle
//   o_bus_drive : sequencer drives its operand onto sysbus
module alu_seq_decode
   import alu_seq_pkg::*;
(
   input  state_t          i_state,
   input  logic [OP_W-1:0] i_op,
   input  logic            i_z_flag,
   output strobe_t         o_strobe,
   output logic            o_bus_drive
);

   // op strobes are mutually exclusive; acc_bus never coexists with the bus drive
   always_comb begin
      o_strobe    = '0;
      o_bus_drive = 1'b0;
      if (i_state == EXEC) begin
         case (i_op)
            OP_LOAD: begin
               o_strobe.load_acc = 1'b1;
               o_bus_drive       = 1'b1;
            end
            OP_ADD: begin
               o_strobe.load_acc = 1'b1;
               o_strobe.alu_acc  = 1'b1;
               o_strobe.alu_add  = 1'b1;
               o_bus_drive       = 1'b1;
            end
            OP_DEC: begin
               o_strobe.load_acc = 1'b1;
               o_strobe.alu_acc  = 1'b1;
               o_strobe.alu_sub  = 1'b1;
            end
            OP_LSH: begin
               o_strobe.load_acc   = 1'b1;
               o_strobe.alu_acc    = 1'b1;
               o_strobe.alu_lshift = 1'b1;
            end
            OP_RSH: begin
               o_strobe.load_acc   = 1'b1;
               o_strobe.alu_acc    = 1'b1;
               o_strobe.alu_rshift = 1'b1;
            end
            OP_MOD2: begin
               o_strobe.load_acc = 1'b1;
               o_strobe.alu_mod2 = 1'b1;
            end
            OP_READ: begin
               o_strobe.acc_bus = 1'b1;
            end
            OP_CNTDN: begin
               // stop decrementing as soon as the accumulator reads zero
               if (!i_z_flag) begin
                  o_strobe.load_acc = 1'b1;
                  o_strobe.alu_acc  = 1'b1;
                  o_strobe.alu_sub  = 1'b1;
               end
            end
            default: begin
               o_strobe    = '0;
               o_bus_drive = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/alu_sequencer.sv
// Command-driven controller for the accumulator ALU.
// Accepts one command at a time over cmd valid/ready, sequences the ALU
// strobes (iterating shifts and count-down-to-zero), shares sysbus with the
// ALU and returns a result over rsp valid/ready.
//   clock, reset           : clock and async active-high reset
//   cmd_valid/ready        : command handshake
//   cmd_op/data/count      : opcode, LOAD/ADD operand, LSH/RSH count
//   rsp_valid/ready        : response handshake
//   rsp_data               : READ value or CNTDN iteration count, else 0
//   rsp_zero               : accumulator-zero flag seen in DONE
//   ACC_bus .. ALU_mod2    : ALU control strobes
//   sysbus                 : shared bus, driven only for LOAD/ADD in EXEC
//   z_flag                 : ALU accumulator-zero flag
// The ALU that pairs with this block takes n_reset = ~reset.
module alu_sequencer
   import alu_seq_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [OP_W-1:0]   cmd_op,
   input  logic [WORD_W-1:0] cmd_data,
   input  logic [CNT_W-1:0]  cmd_count,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [WORD_W-1:0] rsp_data,
   output logic              rsp_zero,
   output logic              ACC_bus,
   output logic              load_ACC,
   output logic              ALU_ACC,
   output logic              ALU_add,
   output logic              ALU_sub,
   output logic              ALU_lshift,
   output logic              ALU_rshift,
   output logic              ALU_mod2,
   inout  wire  [WORD_W-1:0] sysbus,
   input  logic              z_flag
);

   state_t              r_state;
   logic [OP_W-1:0]     r_op;
   logic [WORD_W-1:0]   r_data;
   logic [CNT_W-1:0]    r_count;
   logic [WORD_W-1:0]   r_iter;
   logic [WORD_W-1:0]   r_rsp_data;
   logic                r_rsp_valid;
   logic                r_cmd_ready;

   strobe_t             w_strobe;
   logic                w_bus_drive;
   logic [WORD_W-1:0]   w_iter_inc;

   assign w_iter_inc = r_iter + WORD_W'(1);

   alu_seq_decode u_decode (
      .i_state     (r_state),
      .i_op        (r_op),
      .i_z_flag    (z_flag),
      .o_strobe    (w_strobe),
      .o_bus_drive (w_bus_drive)
   );

   assign ACC_bus    = w_strobe.acc_bus;
   assign load_ACC   = w_strobe.load_acc;
   assign ALU_ACC    = w_strobe.alu_acc;
   assign ALU_add    = w_strobe.alu_add;
   assign ALU_sub    = w_strobe.alu_sub;
   assign ALU_lshift = w_strobe.alu_lshift;
   assign ALU_rshift = w_strobe.alu_rshift;
   assign ALU_mod2   = w_strobe.alu_mod2;

   assign sysbus = w_bus_drive ? r_data : {WORD_W{1'bz}};

   assign cmd_ready = r_cmd_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   // no strobes fire in DONE, so the accumulator and z_flag are frozen there
   assign rsp_zero  = (r_state == DONE) & z_flag;

   // sequencer FSM with its command, counter and response registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_op        <= OP_LOAD;
         r_data      <= '0;
         r_count     <= '0;
         r_iter      <= '0;
         r_rsp_data  <= '0;
         r_rsp_valid <= 1'b0;
         r_cmd_ready <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_cmd_ready <= 1'b1;
               if (cmd_valid && r_cmd_ready) begin
                  r_op        <= cmd_op;
                  r_data      <= cmd_data;
                  r_count     <= cmd_count;
                  r_iter      <= '0;
                  r_rsp_data  <= '0;
                  r_cmd_ready <= 1'b0;
                  // a zero-length shift has nothing to execute
                  if ((cmd_op == OP_LSH || cmd_op == OP_RSH) && cmd_count == '0) begin
                     r_state     <= DONE;
                     r_rsp_valid <= 1'b1;
                  end else begin
                     r_state <= EXEC;
                  end
               end
            end
            EXEC: begin
               case (r_op)
                  OP_LSH, OP_RSH: begin
                     r_iter <= w_iter_inc;
                     if (w_iter_inc == WORD_W'(r_count)) begin
                        r_state     <= DONE;
                        r_rsp_valid <= 1'b1;
                     end
                  end
                  OP_CNTDN: begin
                     if (z_flag) begin
                        r_rsp_data  <= r_iter;
                        r_state     <= DONE;
                        r_rsp_valid <= 1'b1;
                     end else begin
                        r_iter <= w_iter_inc;
                     end
                  end
                  OP_READ: begin
                     // ALU is driving the accumulator onto sysbus this cycle
                     r_rsp_data  <= sysbus;
                     r_state     <= DONE;
                     r_rsp_valid <= 1'b1;
                  end
                  default: begin
                     r_state     <= DONE;
                     r_rsp_valid <= 1'b1;
                  end
               endcase
            end
            DONE: begin
               if (rsp_ready) begin
                  r_state     <= IDLE;
                  r_rsp_valid <= 1'b0;
                  r_cmd_ready <= 1'b1;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_rsp_valid <= 1'b0;
               r_cmd_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: pairs the sequencer with a behavioural accumulator
// ALU, runs directed and random command streams and compares every response
// with an arithmetic model of the accumulator.
module tb_alu_sequencer;
   import alu_seq_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [7:0]  cmd_data;
   logic [3:0]  cmd_count;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [7:0]  rsp_data;
   logic        rsp_zero;
   logic        ACC_bus, load_ACC, ALU_ACC, ALU_add, ALU_sub;
   logic        ALU_lshift, ALU_rshift, ALU_mod2;
   wire  [7:0]  sysbus;
   logic        z_flag;

   int          n_checks = 0;
   int          n_errors = 0;
   int          n_viol   = 0;
   logic [7:0]  model_acc;

   alu_sequencer dut (
      .clock      (clock),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_data   (cmd_data),
      .cmd_count  (cmd_count),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_zero   (rsp_zero),
      .ACC_bus    (ACC_bus),
      .load_ACC   (load_ACC),
      .ALU_ACC    (ALU_ACC),
      .ALU_add    (ALU_add),
      .ALU_sub    (ALU_sub),
      .ALU_lshift (ALU_lshift),
      .ALU_rshift (ALU_rshift),
      .ALU_mod2   (ALU_mod2),
      .sysbus     (sysbus),
      .z_flag     (z_flag)
   );

   always #5 clock = ~clock;

   // behavioural accumulator ALU sharing sysbus with the sequencer
   logic       n_reset;
   logic [7:0] alu_acc;
   assign n_reset = ~reset;
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset)
         alu_acc <= 8'h00;
      else if (load_ACC) begin
         if (ALU_ACC) begin
            if (ALU_add)         alu_acc <= alu_acc + sysbus;
            else if (ALU_sub)    alu_acc <= alu_acc - 8'd1;
            else if (ALU_lshift) alu_acc <= alu_acc << 1;
            else if (ALU_rshift) alu_acc <= alu_acc >> 1;
         end else if (ALU_mod2)
            alu_acc <= alu_acc % 8'd2;
         else
            alu_acc <= sysbus;
      end
   end
   assign z_flag = (alu_acc == 8'h00);
   assign sysbus = ACC_bus ? alu_acc : 8'bz;

   logic [7:0] strobes;
   assign strobes = {ACC_bus, load_ACC, ALU_ACC, ALU_add, ALU_sub, ALU_lshift, ALU_rshift, ALU_mod2};

   // bus/strobe invariants: sequencer drives sysbus exactly when load_ACC is
   // high without a shift/sub/mod2, so ACC_bus with load_ACC means two drivers
   always @(negedge clock) begin
      if (!reset) begin
         if (ACC_bus && load_ACC) n_viol++;
         if ($countones({ALU_add, ALU_sub, ALU_lshift, ALU_rshift, ALU_mod2}) > 1) n_viol++;
         if (rsp_valid && strobes != 8'h00) n_viol++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // issue one command, follow it to its response and compare with the model
   task automatic run_op(input logic [2:0] op, input logic [7:0] data,
                         input logic [3:0] cnt, input int hold);
      int t, cyc, n_ld, n_bus, n_sh, n_sub;
      int exp_lat, exp_ld, exp_bus, exp_sh, exp_sub;
      logic [7:0] exp_acc, exp_data, d0;
      logic z0;
      bit seen, stable;

      t = 0;
      while (!cmd_ready && t < 50) begin
         @(negedge clock);
         t++;
      end
      chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);

      exp_acc = model_acc; exp_data = 8'h00; exp_lat = 2;
      exp_ld = 0; exp_bus = 0; exp_sh = 0; exp_sub = 0;
      case (op)
         OP_LOAD:  begin exp_acc = data; exp_ld = 1; end
         OP_ADD:   begin exp_acc = model_acc + data; exp_ld = 1; end
         OP_DEC:   begin exp_acc = model_acc - 8'd1; exp_ld = 1; exp_sub = 1; end
         OP_LSH:   begin exp_acc = model_acc << cnt; exp_ld = int'(cnt); exp_sh = int'(cnt);
                         exp_lat = (cnt == 0) ? 1 : int'(cnt) + 1; end
         OP_RSH:   begin exp_acc = model_acc >> cnt; exp_ld = int'(cnt); exp_sh = int'(cnt);
                         exp_lat = (cnt == 0) ? 1 : int'(cnt) + 1; end
         OP_MOD2:  begin exp_acc = model_acc % 8'd2; exp_ld = 1; end
         OP_READ:  begin exp_data = model_acc; exp_bus = 1; end
         default:  begin exp_data = model_acc; exp_acc = 8'h00; exp_ld = int'(model_acc);
                         exp_sub = int'(model_acc); exp_lat = int'(model_acc) + 2; end
      endcase

      cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_count = cnt;
      @(posedge clock);
      #1;
      // junk on the command port must be ignored until the sequencer is idle again
      cmd_valid = 1'($urandom); cmd_op = 3'($urandom); cmd_data = 8'($urandom); cmd_count = 4'($urandom);

      cyc = 0; n_ld = 0; n_bus = 0; n_sh = 0; n_sub = 0; seen = 0;
      while (!seen && cyc < 400) begin
         @(negedge clock);
         cyc++;
         if (rsp_valid) seen = 1;
         else begin
            n_ld  += int'(load_ACC);
            n_bus += int'(ACC_bus);
            n_sh  += int'(ALU_lshift) + int'(ALU_rshift);
            n_sub += int'(ALU_sub);
            rsp_ready = 1'($urandom);
         end
      end
      rsp_ready = 1'b0;
      chk("rsp_seen", 32'(seen), 32'd1);
      chk("latency", 32'(cyc), 32'(exp_lat));
      chk("rsp_data", 32'(rsp_data), 32'(exp_data));
      chk("rsp_zero", 32'(rsp_zero), 32'(exp_acc == 8'h00));
      chk("cmd_ready_done", 32'(cmd_ready), 32'd0);
      chk("n_load", 32'(n_ld), 32'(exp_ld));
      chk("n_accbus", 32'(n_bus), 32'(exp_bus));
      chk("n_shift", 32'(n_sh), 32'(exp_sh));
      chk("n_sub", 32'(n_sub), 32'(exp_sub));

      d0 = rsp_data; z0 = rsp_zero; stable = 1;
      for (int i = 0; i < hold; i++) begin
         @(negedge clock);
         if (rsp_valid !== 1'b1 || rsp_data !== d0 || rsp_zero !== z0 || cmd_ready !== 1'b0)
            stable = 0;
      end
      if (hold > 0) chk("hold_stable", 32'(stable), 32'd1);

      rsp_ready = 1'b1;
      @(posedge clock);
      #1;
      rsp_ready = 1'b0;
      cmd_valid = 1'b0;
      model_acc = exp_acc;
      @(negedge clock);
      chk("acc", 32'(alu_acc), 32'(model_acc));
      chk("rsp_valid_clr", 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 8'h00; cmd_count = 4'd0;
      rsp_ready = 1'b0; model_acc = 8'h00;
      #12;
      chk("rst_strobes", 32'(strobes), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data", 32'(rsp_data), 32'd0);
      chk("rst_rsp_zero", 32'(rsp_zero), 32'd0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      @(negedge clock);
      reset = 1'b0;

      run_op(OP_LOAD, 8'h3C, 4'd0, 0);
      run_op(OP_READ, 8'h00, 4'd0, 0);
      run_op(OP_LOAD, 8'h05, 4'd0, 0);
      run_op(OP_ADD,  8'h0A, 4'd0, 0);
      run_op(OP_LSH,  8'h00, 4'd2, 0);
      run_op(OP_RSH,  8'h00, 4'd0, 0);
      run_op(OP_LOAD, 8'h00, 4'd0, 0);
      run_op(OP_DEC,  8'h00, 4'd0, 0);
      run_op(OP_MOD2, 8'h00, 4'd0, 0);
      run_op(OP_CNTDN, 8'h00, 4'd0, 0);
      run_op(OP_LOAD, 8'h07, 4'd0, 0);
      run_op(OP_CNTDN, 8'h00, 4'd0, 0);
      run_op(OP_LOAD, 8'h00, 4'd0, 0);
      run_op(OP_CNTDN, 8'h00, 4'd0, 0);
      run_op(OP_LOAD, 8'hA5, 4'd0, 0);
      run_op(OP_READ, 8'h00, 4'd0, 5);

      // reset in the middle of a long shift
      while (!cmd_ready) @(negedge clock);
      cmd_valid = 1'b1; cmd_op = OP_LSH; cmd_data = 8'h00; cmd_count = 4'd10;
      @(posedge clock);
      #1 cmd_valid = 1'b0;
      repeat (3) @(negedge clock);
      chk("mid_lsh_active", 32'(ALU_lshift), 32'd1);
      reset = 1'b1;
      #1;
      chk("mid_rst_strobes", 32'(strobes), 32'd0);
      chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      model_acc = 8'h00;
      repeat (2) @(negedge clock);
      chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("post_rst_strobes", 32'(strobes), 32'd0);
      run_op(OP_LOAD, 8'h81, 4'd0, 0);
      run_op(OP_READ, 8'h00, 4'd0, 0);

      for (int k = 0; k < 60; k++)
         run_op(3'($urandom), 8'($urandom), 4'($urandom), int'($urandom_range(0, 3)));

      chk("bus_invariants", 32'(n_viol), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
